// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory stage.
// Used by data_mem_ctrl and dmem_ram.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10
  } mem_type_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  // Lane enables for a store; low address bits beyond the access size are ignored.
  function automatic logic [3:0] byte_en(input logic [1:0] mtype, input logic [1:0] addr);
    case (mtype)
      MEM_BYTE: byte_en = 4'b0001 << addr;
      MEM_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:  byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] mtype, input logic [1:0] addr);
    case (mtype)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr[0];
      default:  is_misaligned = (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, byte-enabled writes, read-first.
// Read data updates only on enabled cycles; contents are never reset.
module dmem_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_idx];
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: aligned/byte-enabled stores, 1-cycle loads with a held response.
// Optional MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing alignment.
//
// state | meaning
// EMPTY | no load response pending
// FULL  | load response presented on rsp_* outputs
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] write_data_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  mem_sign_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] read_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic [1:0]            rsp_type_o,
  output logic                  rsp_sign_o,
  output logic                  misalign_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  rsp_state_t            r_state, w_state_nxt;
  logic                  w_accept, w_ld_acc, w_mis;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_wdata, w_ram_rdata;
  logic [ADDR_WIDTH-1:0] r_hold, r_addr;
  logic [1:0]            r_type;
  logic                  r_sign, r_fresh, r_zero;

  assign w_accept = req_valid_i && req_ready_o;
  assign w_ld_acc = w_accept && !req_we_i;

`ifdef MISALIGN_TRAP_EN
  assign w_mis = is_misaligned(mem_type_i, addr_i[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // A trapped store keeps the RAM untouched by dropping every lane enable.
  assign w_be = w_mis ? 4'b0000 : byte_en(mem_type_i, addr_i[1:0]);

  always_comb begin
    w_wdata = write_data_i;
    case (mem_type_i)
      MEM_BYTE: w_wdata = {4{write_data_i[7:0]}};
      MEM_HALF: w_wdata = {2{write_data_i[15:0]}};
      default:  w_wdata = write_data_i;
    endcase
  end

  dmem_ram #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_accept),
    .i_we   (req_we_i),
    .i_be   (w_be),
    .i_idx  (addr_i[2 +: IDX_W]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_ld_acc) w_state_nxt = FULL;
      FULL:    if (!w_ld_acc && rsp_ready_i) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid_o = (r_state == FULL);
    req_ready_o = (r_state == EMPTY) || rsp_ready_i;
  end

  // RAM word is live for one cycle after the read, then served from r_hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_type  <= 2'b00;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_fresh <= 1'b0;
      r_hold  <= '0;
    end else begin
      if (w_ld_acc) begin
        r_addr <= addr_i;
        r_type <= mem_type_i;
        r_sign <= mem_sign_i;
        r_zero <= w_mis;
      end
      r_fresh <= w_ld_acc;
      if (r_fresh) r_hold <= w_ram_rdata;
    end
  end

  assign read_data_o = r_zero ? '0 : (r_fresh ? w_ram_rdata : r_hold);
  assign rsp_addr_o  = r_addr;
  assign rsp_type_o  = r_type;
  assign rsp_sign_o  = r_sign;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_accept && w_mis;
  end
  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-level memory model plus directed and random traffic.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_ctrl;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req_valid_i, req_ready_o, req_we_i, mem_sign_i;
  logic [AW-1:0] addr_i, write_data_i;
  logic [1:0]    mem_type_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_sign_o, misalign_o;
  logic [AW-1:0] read_data_o, rsp_addr_o;
  logic [1:0]    rsp_type_o;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .mem_type_i(mem_type_i),
    .mem_sign_i(mem_sign_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .read_data_o(read_data_o), .rsp_addr_o(rsp_addr_o), .rsp_type_o(rsp_type_o),
    .rsp_sign_o(rsp_sign_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: byte array of the whole RAM and the single pending response.
  logic [7:0]  mem_m [BYTES];
  bit          m_valid, m_mis, m_sign;
  logic [31:0] m_data, m_addr;
  logic [1:0]  m_type;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b;
    b = int'(a[11:0]) & ~3;
    return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
  endfunction

  function automatic bit m_misal(input logic [1:0] t, input logic [1:0] a);
    if (t == 2'b01) return 1'b0;
    if (t == 2'b10) return a[0];
    return a != 2'b00;
  endfunction

  task automatic compare();
    chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_valid});
    chk("req_ready", {31'd0, req_ready_o}, {31'd0, (!m_valid || rsp_ready_i)});
    chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    if (m_valid) begin
      chk("read_data", read_data_o, m_data);
      chk("rsp_addr", rsp_addr_o, m_addr);
      chk("rsp_type", {30'd0, rsp_type_o}, {30'd0, m_type});
      chk("rsp_sign", {31'd0, rsp_sign_o}, {31'd0, m_sign});
    end
  endtask

  task automatic model_step();
    bit          acc, bad;
    int          ea, b;
    logic [31:0] a, wd;
    a   = addr_i;
    wd  = write_data_i;
    acc = req_valid_i && (!m_valid || rsp_ready_i);
    bad = TRAP && m_misal(mem_type_i, a[1:0]);
    ea  = int'(a[11:0]);
    m_mis = acc && bad;
    if (acc && req_we_i) begin
      if (!bad) begin
        if (mem_type_i == 2'b01) begin
          mem_m[ea] = wd[7:0];
        end else if (mem_type_i == 2'b10) begin
          b = ea & ~1;
          mem_m[b] = wd[7:0]; mem_m[b+1] = wd[15:8];
        end else begin
          b = ea & ~3;
          for (int k = 0; k < 4; k++) mem_m[b+k] = wd[8*k +: 8];
        end
      end
    end
    if (acc && !req_we_i) begin
      m_valid = 1'b1;
      m_data  = bad ? 32'd0 : m_word(a);
      m_addr  = a;
      m_type  = mem_type_i;
      m_sign  = mem_sign_i;
    end else if (rsp_ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] t, input bit s, input bit rr);
    @(negedge clk);
    req_valid_i = v; req_we_i = we; addr_i = a; write_data_i = wd;
    mem_type_i = t; mem_sign_i = s; rsp_ready_i = rr;
    #1;
    compare();
    model_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    rst_n = 1'b0;
    req_valid_i = 0; req_we_i = 0; addr_i = '0; write_data_i = '0;
    mem_type_i = 2'b00; mem_sign_i = 0; rsp_ready_i = 0;
    m_valid = 0; m_mis = 0; m_sign = 0; m_data = '0; m_addr = '0; m_type = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset read_data", read_data_o, 32'd0);
    chk("reset rsp_addr", rsp_addr_o, 32'd0);
    chk("reset misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) cycle(1, 1, i * 4, $urandom, 2'b00, 0, 1);

    // word store then load
    cycle(1, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, 1);
    cycle(1, 0, 32'h10, 32'h0, 2'b00, 1, 1);
    after_edge();
    chk("t1 rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("t1 read_data", read_data_o, 32'hDEADBEEF);
    chk("t1 rsp_addr", rsp_addr_o, 32'h10);

    // byte and half lanes
    cycle(1, 1, 32'h10, 32'h0, 2'b00, 0, 1);
    cycle(1, 1, 32'h13, 32'h55AA_77A5, 2'b01, 0, 1);
    cycle(1, 0, 32'h10, 32'h0, 2'b01, 0, 1);
    after_edge();
    chk("t2 sb", read_data_o, 32'hA500_0000);
    cycle(1, 1, 32'h12, 32'h9999_1234, 2'b10, 0, 1);
    cycle(1, 0, 32'h10, 32'h0, 2'b10, 0, 1);
    after_edge();
    chk("t2 sh", read_data_o, 32'h1234_0000);

    // backpressure on back-to-back loads
    cycle(1, 1, 32'h20, 32'h1111_2222, 2'b00, 0, 1);
    cycle(1, 1, 32'h24, 32'h3333_4444, 2'b00, 0, 1);
    cycle(1, 0, 32'h20, 32'h0, 2'b00, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'h24, 32'h0, 2'b00, 1, 0);
    chk("t3 held data", read_data_o, 32'h1111_2222);
    chk("t3 held addr", rsp_addr_o, 32'h20);
    chk("t3 ready low", {31'd0, req_ready_o}, 32'd0);
    cycle(1, 0, 32'h24, 32'h0, 2'b00, 1, 1);
    after_edge();
    chk("t3 second data", read_data_o, 32'h3333_4444);
    chk("t3 second addr", rsp_addr_o, 32'h24);
    chk("t3 second sign", {31'd0, rsp_sign_o}, 32'd1);

    // reset with a pending response
    cycle(1, 0, 32'h24, 32'h0, 2'b00, 0, 0);
    after_edge();
    chk("t4 pre-reset valid", {31'd0, rsp_valid_o}, 32'd1);
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("t4 reset valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("t4 reset data", read_data_o, 32'd0);
    m_valid = 0; m_mis = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 32'h20, 32'h0, 2'b00, 0, 1);
    after_edge();
    chk("t4 persist", read_data_o, 32'h1111_2222);

    // address wrap
    cycle(1, 1, BYTES + 32'h8, 32'hCAFE_F00D, 2'b00, 0, 1);
    cycle(1, 0, 32'h8, 32'h0, 2'b00, 0, 1);
    after_edge();
    chk("t5 wrap", read_data_o, 32'hCAFE_F00D);

    // misaligned word load
    cycle(1, 0, 32'h11, 32'h0, 2'b00, 0, 1);
    after_edge();
`ifdef MISALIGN_TRAP_EN
    chk("t6 misalign", {31'd0, misalign_o}, 32'd1);
    chk("t6 data", read_data_o, 32'd0);
`else
    chk("t6 misalign", {31'd0, misalign_o}, 32'd0);
    chk("t6 data", read_data_o, 32'h1234_0000);
`endif

    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end
    cycle(0, 0, 32'h0, 32'h0, 2'b00, 0, 1);
    cycle(0, 0, 32'h0, 32'h0, 2'b00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
